// File: rtl/mbinit_delay_scheduler.sv
// Round-robin launcher that shares one fixed-latency delay line among NUM_REQ requesters.
// A {valid,id} tag pipeline keeps pace with the delay line so that each returning payload is labelled with its owner.
module mbinit_delay_scheduler #(
  parameter int DELAY_CYCLES = 6,
  parameter int SIGNAL_WIDTH = 4,
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  localparam int ID_W        = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(DELAY_CYCLES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*SIGNAL_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [SIGNAL_WIDTH-1:0]         dly_in,
  input  logic [SIGNAL_WIDTH-1:0]         dly_out,
  output logic                            rsp_valid,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [SIGNAL_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]              pending,
  output logic [CNT_W-1:0]                in_flight,
  output logic                            idle,
  output logic [1:0]                      dbg_state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             launch;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] retire_mask;
  logic             tag_v  [DELAY_CYCLES];
  logic [ID_W-1:0]  tag_id [DELAY_CYCLES];

  assign dbg_state = state;
  assign eligible  = req_valid & ~pending;

  // Handshake: a payload transfers in any cycle where req_valid[i] & req_ready[i];
  // req_ready is one-hot or zero, and a request dropped before its grant leaves no trace.
  always_comb begin
    launch = 1'b0;
    winner = '0;
    cand   = '0;
    if (state == ST_READY && en) begin
      for (int s = 1; s <= NUM_REQ; s++) begin
        cand = ID_W'((int'(rr_ptr) + s) % NUM_REQ);
        if (!launch && eligible[cand]) begin
          launch = 1'b1;
          winner = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    dly_in    = '0;
    if (launch) begin
      req_ready[winner] = 1'b1;
      dly_in = req_data[int'(winner)*SIGNAL_WIDTH +: SIGNAL_WIDTH];
    end
  end

  assign rsp_valid = tag_v[DELAY_CYCLES-1];
  assign rsp_id    = tag_id[DELAY_CYCLES-1];
  assign rsp_data  = rsp_valid ? dly_out : '0;
  assign idle      = (in_flight == '0);

  always_comb begin
    retire_mask = '0;
    if (rsp_valid) retire_mask[rsp_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_READY;
      gap_cnt <= '0;
      rr_ptr  <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_READY: begin
          if (!en && in_flight != '0) begin
            state   <= ST_DRAIN;
            gap_cnt <= '0;
          end else if (launch) begin
            rr_ptr <= winner;
            if (GAP_CYCLES > 0) begin
              state   <= ST_HOLD;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (!en && in_flight != '0) begin
            state   <= ST_DRAIN;
            gap_cnt <= '0;
          end else if (gap_cnt == '0) begin
            state <= ST_READY;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (en || in_flight == '0) state <= ST_READY;
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Tags travel alongside the payload so the last stage lines up with dly_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DELAY_CYCLES; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      tag_v[0]  <= launch;
      tag_id[0] <= winner;
      for (int s = 1; s < DELAY_CYCLES; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      in_flight <= '0;
    end else begin
      pending <= (pending & ~retire_mask) | req_ready;
      if (launch && !rsp_valid) in_flight <= in_flight + CNT_W'(1);
      else if (!launch && rsp_valid) in_flight <= in_flight - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (in_flight <= CNT_W'(DELAY_CYCLES));
      assert (!(rsp_valid && in_flight == '0));
      assert (!(launch && !rsp_valid && in_flight == CNT_W'(DELAY_CYCLES)));
    end
  end

endmodule

// File: tb/tb_mbinit_delay_scheduler.sv
// Bench for mbinit_delay_scheduler: two instances (gap 0 and gap 2) share stimulus and are
// compared each cycle against a per-requester reference model plus directed expectations.
module tb_mbinit_delay_scheduler;

  localparam int N    = 4;
  localparam int SW   = 4;
  localparam int D    = 6;
  localparam int IDW  = 2;
  localparam int CW   = 3;
  localparam int SNAP = N + SW + 1 + IDW + SW + N + CW + 1;

  logic            clk;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N*SW-1:0] req_data;

  logic [N-1:0]   req_ready [2];
  logic [SW-1:0]  dly_in    [2];
  logic [SW-1:0]  dly_out   [2];
  logic           rsp_valid [2];
  logic [IDW-1:0] rsp_id    [2];
  logic [SW-1:0]  rsp_data  [2];
  logic [N-1:0]   pending   [2];
  logic [CW-1:0]  in_flight [2];
  logic           idle      [2];
  logic [1:0]     dbg_state [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: per requester, the cycle its payload returns (-1 when none)
  int            m_due  [2][N];
  logic [SW-1:0] m_data [2][N];
  int            m_ptr  [2];
  int            m_hold [2];
  bit            m_drain[2];
  int            m_win  [2];
  int            m_rid  [2];
  int            m_cnt  [2];
  logic [SNAP-1:0] exp_snap [2];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [SW-1:0] line [D];

    mbinit_delay_scheduler #(
      .DELAY_CYCLES(D), .SIGNAL_WIDTH(SW), .NUM_REQ(N), .GAP_CYCLES(2*g)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready[g]),
      .dly_in(dly_in[g]), .dly_out(dly_out[g]),
      .rsp_valid(rsp_valid[g]), .rsp_id(rsp_id[g]), .rsp_data(rsp_data[g]),
      .pending(pending[g]), .in_flight(in_flight[g]), .idle(idle[g]),
      .dbg_state(dbg_state[g])
    );

    // external delay line; deliberately not reset so stale data survives a reset
    always @(posedge clk) begin
      line[0] <= dly_in[g];
      for (int s = 1; s < D; s++) line[s] <= line[s-1];
    end
    assign dly_out[g] = line[D-1];
  end

  // ---------------- model ----------------
  function automatic logic [SNAP-1:0] obs(input int k);
    return {req_ready[k], dly_in[k], rsp_valid[k], rsp_id[k], rsp_data[k],
            pending[k], in_flight[k], idle[k]};
  endfunction

  task automatic eval_model(input int k);
    int win;
    int rid;
    int cnt;
    logic [N-1:0]  rdy;
    logic [N-1:0]  pend;
    logic [SW-1:0] din;
    logic [SW-1:0] rdata;
    win = -1; rid = -1; cnt = 0;
    rdy = '0; pend = '0; din = '0; rdata = '0;
    if (en && !m_drain[k] && m_hold[k] == 0) begin
      for (int s = 1; s <= N; s++) begin
        int j;
        j = (m_ptr[k] + s) % N;
        if (win < 0 && req_valid[j] && m_due[k][j] < 0) win = j;
      end
    end
    if (win >= 0) begin
      rdy[win] = 1'b1;
      din = req_data[win*SW +: SW];
    end
    for (int i = 0; i < N; i++) begin
      if (m_due[k][i] >= 0) begin
        pend[i] = 1'b1;
        cnt++;
      end
      if (m_due[k][i] == cyc) begin
        rid = i;
        rdata = m_data[k][i];
      end
    end
    m_win[k] = win;
    m_rid[k] = rid;
    m_cnt[k] = cnt;
    exp_snap[k] = {rdy, din, (rid >= 0), IDW'((rid >= 0) ? rid : 0), rdata,
                   pend, CW'(cnt), (cnt == 0)};
  endtask

  task automatic commit_model(input int k);
    bit drain_next;
    if (rst) begin
      m_ptr[k] = N - 1;
      m_hold[k] = 0;
      m_drain[k] = 1'b0;
      for (int i = 0; i < N; i++) m_due[k][i] = -1;
      return;
    end
    if (m_rid[k] >= 0) m_due[k][m_rid[k]] = -1;
    drain_next = !en && m_cnt[k] > 0;
    if (m_win[k] >= 0) begin
      m_due[k][m_win[k]]  = cyc + D;
      m_data[k][m_win[k]] = req_data[m_win[k]*SW +: SW];
      m_ptr[k]  = m_win[k];
      m_hold[k] = 2 * k;
    end else if (drain_next) begin
      m_hold[k] = 0;
    end else if (m_hold[k] > 0) begin
      m_hold[k]--;
    end
    m_drain[k] = drain_next;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_eval();
    @(negedge clk);
    for (int k = 0; k < 2; k++) eval_model(k);
  endtask

  task automatic tick_commit();
    @(posedge clk);
    for (int k = 0; k < 2; k++) commit_model(k);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    repeat (2) begin
      tick_eval();
      tick_commit();
    end
    rst = 1'b0; en = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tick_eval();
    checks++; if (req_ready[0] !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready[0]); end
    checks++; if (dly_in[0] !== 4'h0) begin errors++; $display("FAIL reset_dly_in: got %h exp 0", dly_in[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid[0]); end
    checks++; if (rsp_id[0] !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d exp 0", rsp_id[0]); end
    checks++; if (rsp_data[0] !== 4'h0) begin errors++; $display("FAIL reset_rsp_data: got %h exp 0", rsp_data[0]); end
    checks++; if (pending[0] !== 4'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0000", pending[0]); end
    checks++; if (in_flight[0] !== 3'd0) begin errors++; $display("FAIL reset_in_flight: got %0d exp 0", in_flight[0]); end
    checks++; if (idle[0] !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b exp 1", idle[0]); end
    tick_commit();
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      req_valid = (c == 5) ? 4'b0100 : 4'b0000;
      req_data  = (c == 5) ? 16'h0A00 : 16'($urandom);
      tick_eval();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs(k) !== exp_snap[k]) begin errors++; $display("FAIL single dut%0d c=%0d: got %h exp %h", k, c, obs(k), exp_snap[k]); end
      end
      if (c == 5) begin
        checks++; if (req_ready[0] !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b exp 0100", req_ready[0]); end
      end
      if (c == 11) begin
        checks++; if ({rsp_valid[0], rsp_id[0], rsp_data[0]} !== {1'b1, 2'd2, 4'hA}) begin errors++; $display("FAIL single_rsp: got v=%b id=%0d d=%h exp v=1 id=2 d=a", rsp_valid[0], rsp_id[0], rsp_data[0]); end
      end
      if (c >= 6 && c <= 11) begin
        checks++; if (pending[0][2] !== 1'b1) begin errors++; $display("FAIL single_pending c=%0d: got %b exp 1", c, pending[0][2]); end
      end
      if (c == 12) begin
        checks++; if (idle[0] !== 1'b1) begin errors++; $display("FAIL single_idle: got %b exp 1", idle[0]); end
      end
      tick_commit();
    end
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] peak;
    logic [N-1:0]  exp_rdy;
    peak = '0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req_valid = 4'hF;
      req_data  = 16'($urandom);
      tick_eval();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs(k) !== exp_snap[k]) begin errors++; $display("FAIL rr dut%0d c=%0d: got %h exp %h", k, c, obs(k), exp_snap[k]); end
      end
      if (c <= 7) begin
        exp_rdy = (c < 4) ? (4'b0001 << c) : ((c == 7) ? 4'b0001 : 4'b0000);
        checks++; if (req_ready[0] !== exp_rdy) begin errors++; $display("FAIL rr_order c=%0d: got %b exp %b", c, req_ready[0], exp_rdy); end
      end
      if (in_flight[0] > peak) peak = in_flight[0];
      tick_commit();
    end
    checks++; if (peak !== 3'd4) begin errors++; $display("FAIL rr_peak: got %0d exp 4", peak); end
  endtask

  task automatic test_gap();
    logic [N-1:0] exp_g [4];
    exp_g = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b0011;
      req_data  = 16'($urandom);
      tick_eval();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs(k) !== exp_snap[k]) begin errors++; $display("FAIL gap dut%0d c=%0d: got %h exp %h", k, c, obs(k), exp_snap[k]); end
      end
      if (c < 4) begin
        checks++; if (req_ready[1] !== exp_g[c]) begin errors++; $display("FAIL gap_slot c=%0d: got %b exp %b", c, req_ready[1], exp_g[c]); end
      end
      tick_commit();
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      en        = (c < 3 || c >= 15);
      req_valid = 4'hF;
      req_data  = 16'($urandom);
      tick_eval();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs(k) !== exp_snap[k]) begin errors++; $display("FAIL drain dut%0d c=%0d: got %h exp %h", k, c, obs(k), exp_snap[k]); end
      end
      if (c == 5) begin
        checks++; if (dbg_state[0] !== 2'd2) begin errors++; $display("FAIL drain_state: got %0d exp 2", dbg_state[0]); end
      end
      if (c == 11) begin
        checks++; if ({dbg_state[0], idle[0]} !== {2'd0, 1'b1}) begin errors++; $display("FAIL drain_ready: got st=%0d idle=%b exp st=0 idle=1", dbg_state[0], idle[0]); end
      end
      tick_commit();
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      rst       = (c == 2);
      req_valid = (c == 0) ? 4'b0010 : ((c == 13) ? 4'b1111 : 4'b0000);
      req_data  = 16'($urandom);
      tick_eval();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs(k) !== exp_snap[k]) begin errors++; $display("FAIL rstmid dut%0d c=%0d: got %h exp %h", k, c, obs(k), exp_snap[k]); end
      end
      if (c >= 3) begin
        checks++; if ({rsp_valid[0], pending[0], in_flight[0]} !== 8'b0) begin errors++; $display("FAIL rstmid_clear c=%0d: got v=%b p=%b f=%0d exp all 0", c, rsp_valid[0], pending[0], in_flight[0]); end
      end
      if (c == 13) begin
        checks++; if (req_ready[0] !== 4'b0001) begin errors++; $display("FAIL rstmid_grant: got %b exp 0001", req_ready[0]); end
      end
      tick_commit();
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c == 0) ? 4'b0010 : ((c == 6) ? 4'b1010 : ((c == 7) ? 4'b0010 : 4'b0000));
      req_data  = 16'($urandom);
      tick_eval();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs(k) !== exp_snap[k]) begin errors++; $display("FAIL b2b dut%0d c=%0d: got %h exp %h", k, c, obs(k), exp_snap[k]); end
      end
      if (c == 6) begin
        checks++; if ({req_ready[0], rsp_valid[0], rsp_id[0]} !== {4'b1000, 1'b1, 2'd1}) begin errors++; $display("FAIL b2b_swap: got rdy=%b v=%b id=%0d exp rdy=1000 v=1 id=1", req_ready[0], rsp_valid[0], rsp_id[0]); end
      end
      if (c == 7) begin
        checks++; if ({pending[0], in_flight[0], req_ready[0]} !== {4'b1000, 3'd1, 4'b0010}) begin errors++; $display("FAIL b2b_after: got p=%b f=%0d rdy=%b exp p=1000 f=1 rdy=0010", pending[0], in_flight[0], req_ready[0]); end
      end
      tick_commit();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      en        = ($urandom_range(0, 7) != 0);
      req_valid = 4'($urandom);
      req_data  = 16'($urandom);
      tick_eval();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs(k) !== exp_snap[k]) begin errors++; $display("FAIL random dut%0d c=%0d: got %h exp %h", k, c, obs(k), exp_snap[k]); end
      end
      tick_commit();
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    for (int k = 0; k < 2; k++) begin
      m_win[k] = -1; m_rid[k] = -1; m_cnt[k] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_drain();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
